// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - WIDTH x DEPTH elastic register pipeline with valid/ready on both ends
// Optional observe-only stage tap: define ELASTIC_PIPE_TAP_EN to add tap_sel/tap_valid/tap_data.
`timescale 1ns/1ps

module elastic_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LVLW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [LVLW-1:0]  level
`ifdef ELASTIC_PIPE_TAP_EN
  ,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tap_sel,
  output logic                                         tap_valid,
  output logic [WIDTH-1:0]                             tap_data
`endif
);

  // Per-stage state: valid bit and data word; stage DEPTH-1 faces downstream.
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [LVLW-1:0]  r_level;

  logic [DEPTH-1:0] w_rdy;
  logic             w_full_acc;
  logic             w_accept;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [DEPTH-1:0] w_v_next;
  logic [LVLW-1:0]  w_level_next;

  // Ready chain: a stage can take a beat unless it and every stage after it are full
  // while the output is stalled. Written as a running AND so no vector feeds itself.
  always_comb begin
    w_rdy      = '0;
    w_full_acc = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_full_acc = w_full_acc & r_v[i];
      w_rdy[i]   = ~w_full_acc | out_ready;
    end
  end

  assign in_ready = w_rdy[0] & ~flush & rstn;
  assign w_accept = in_valid & in_ready;

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = w_accept;
    w_src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_v[i-1];
      w_src_data[i]  = r_d[i-1];
    end
  end

  // Next valid vector: flush empties everything, a ready stage loads its source,
  // a stalled stage keeps its beat.
  always_comb begin
    w_v_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        w_v_next[i] = 1'b0;
      end else if (w_rdy[i]) begin
        w_v_next[i] = w_src_valid[i];
      end else begin
        w_v_next[i] = r_v[i];
      end
    end
  end

  // Occupancy of the next state, so level is registered alongside the valid bits.
  always_comb begin
    w_level_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_level_next = w_level_next + LVLW'(w_v_next[i]);
    end
  end

  // Stage registers: all stages move on the same edge using the old predecessor value;
  // data only loads with a valid beat so an idle stage keeps its last word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v     <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v     <= w_v_next;
      r_level <= w_level_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          r_d[i] <= '0;
        end else if (w_rdy[i] && w_src_valid[i]) begin
          r_d[i] <= w_src_data[i];
        end
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign level     = r_level;

`ifdef ELASTIC_PIPE_TAP_EN
  // Observe-only tap of one stage; out-of-range selects read as an empty stage.
  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    if (int'(tap_sel) < DEPTH) begin
      tap_valid = r_v[tap_sel];
      tap_data  = r_d[tap_sel];
    end
  end
`endif

endmodule
